// File: rtl/ped_xing_ctrl.sv
// ped_xing_ctrl: pedestrian-crossing controller with debounced request, clearance and night flash
module ped_xing_ctrl #(
   parameter int TICK_DIV        = 12000000,
   parameter int T_MIN_GREEN     = 4,
   parameter int T_YELLOW        = 3,
   parameter int T_CLEAR         = 1,
   parameter int T_WALK          = 6,
   parameter int T_BLINK         = 4,
   parameter int DEBOUNCE        = 120000,
   parameter int LAMP_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   input  logic       night,
   output logic [2:0] car_lamp,
   output logic [1:0] ped_lamp,
   output logic       req_pending,
   output logic [2:0] state
);
   typedef enum logic [2:0] {
      GREEN  = 3'd0,
      YELLOW = 3'd1,
      CLR1   = 3'd2,
      WALK   = 3'd3,
      BLINK  = 3'd4,
      CLR2   = 3'd5,
      FLASH  = 3'd6
   } state_t;
   localparam int TM1   = T_MIN_GREEN > T_YELLOW ? T_MIN_GREEN : T_YELLOW;
   localparam int TM2   = TM1 > T_CLEAR ? TM1 : T_CLEAR;
   localparam int TM3   = TM2 > T_WALK ? TM2 : T_WALK;
   localparam int T_MAX = TM3 > T_BLINK ? TM3 : T_BLINK;
   localparam int CW    = $clog2(T_MAX + 1);
   localparam int PW    = $clog2(TICK_DIV);
   localparam int DW    = $clog2(DEBOUNCE + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic [1:0]    btn_s_q, btn_s_d, night_s_q, night_s_d;
   logic          acc_q, acc_d, acc_dly_q, acc_dly_d;
   logic          req_q, req_d, phase_q, phase_d;
   logic [2:0]    car_q, car_d;
   logic [1:0]    ped_q, ped_d;
   logic          tick, db_diff, db_accept, rise, entry;

   // next-state: prescaler, synchronisers, debouncer, request latch, FSM and lamp decode
   always_comb begin
      tick      = pre_q == PW'(TICK_DIV - 1);
      pre_d     = tick ? '0 : pre_q + 1'b1;
      btn_s_d   = {btn_s_q[0], btn};
      night_s_d = {night_s_q[0], night};
      db_diff   = btn_s_q[1] != acc_q;
      db_accept = db_diff && db_cnt_q == DW'(DEBOUNCE - 1);
      db_cnt_d  = (db_diff && !db_accept) ? db_cnt_q + 1'b1 : '0;
      acc_d     = db_accept ? btn_s_q[1] : acc_q;
      acc_dly_d = acc_q;
      rise      = acc_q & ~acc_dly_q;
      state_d   = state_q;
      case (state_q)
         GREEN:   if (tick && cnt_q >= CW'(T_MIN_GREEN - 1))
                     state_d = req_q ? YELLOW : night_s_q[1] ? FLASH : GREEN;
         YELLOW:  if (tick && cnt_q == CW'(T_YELLOW - 1)) state_d = CLR1;
         CLR1:    if (tick && cnt_q == CW'(T_CLEAR - 1)) state_d = WALK;
         WALK:    if (tick && cnt_q == CW'(T_WALK - 1)) state_d = BLINK;
         BLINK:   if (tick && cnt_q == CW'(T_BLINK - 1)) state_d = CLR2;
         CLR2:    if (tick && cnt_q == CW'(T_CLEAR - 1)) state_d = GREEN;
         FLASH:   if (tick && !night_s_q[1]) state_d = GREEN;
         default: state_d = GREEN;
      endcase
      entry   = state_d != state_q;
      cnt_d   = entry ? '0 : (tick && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
      phase_d = entry ? 1'b1 : phase_q ^ tick;
      req_d   = (entry && state_d == WALK) ? 1'b0 : req_q | rise;
      car_d   = state_d == GREEN  ? 3'b001 :
                state_d == YELLOW ? 3'b010 :
                state_d == FLASH  ? {1'b0, phase_d, 1'b0} : 3'b100;
      ped_d   = state_d == WALK  ? 2'b01 :
                state_d == BLINK ? {1'b0, phase_d} :
                state_d == FLASH ? 2'b00 : 2'b10;
   end

   // all state registers, cleared asynchronously to the idle car-green state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= GREEN;
         cnt_q     <= '0;
         pre_q     <= '0;
         db_cnt_q  <= '0;
         btn_s_q   <= '0;
         night_s_q <= '0;
         acc_q     <= 1'b0;
         acc_dly_q <= 1'b0;
         req_q     <= 1'b0;
         phase_q   <= 1'b1;
         car_q     <= 3'b001;
         ped_q     <= 2'b10;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pre_q     <= pre_d;
         db_cnt_q  <= db_cnt_d;
         btn_s_q   <= btn_s_d;
         night_s_q <= night_s_d;
         acc_q     <= acc_d;
         acc_dly_q <= acc_dly_d;
         req_q     <= req_d;
         phase_q   <= phase_d;
         car_q     <= car_d;
         ped_q     <= ped_d;
      end
   end

   assign car_lamp    = car_q ^ {3{LAMP_ACTIVE_LOW != 0}};
   assign ped_lamp    = ped_q ^ {2{LAMP_ACTIVE_LOW != 0}};
   assign req_pending = req_q;
   assign state       = state_q;
endmodule

// File: tb/tb_ped_xing_ctrl.sv
// tb_ped_xing_ctrl: directed checks of timing, debounce, night flash and reset behaviour
module tb_ped_xing_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0, btn = 1'b0, night = 1'b0;
   logic [2:0] car_lamp, state;
   logic [1:0] ped_lamp;
   logic       req_pending;
   int         n_chk = 0, n_fail = 0, c = 0;

   ped_xing_ctrl #(
      .TICK_DIV(4), .T_MIN_GREEN(4), .T_YELLOW(3), .T_CLEAR(1), .T_WALK(6),
      .T_BLINK(4), .DEBOUNCE(3), .LAMP_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn(btn), .night(night),
      .car_lamp(car_lamp), .ped_lamp(ped_lamp), .req_pending(req_pending), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] st, input logic [2:0] car,
                          input logic [1:0] ped, input logic rq);
      chk({tag, ".state"}, {5'd0, state}, {5'd0, st});
      chk({tag, ".car"}, {5'd0, car_lamp}, {5'd0, car});
      chk({tag, ".ped"}, {6'd0, ped_lamp}, {6'd0, ped});
      chk({tag, ".req"}, {7'd0, req_pending}, {7'd0, rq});
   endtask

   task automatic go(input int t);
      while (c < t) begin
         @(posedge clk);
         c++;
      end
      #1;
   endtask

   task automatic do_reset();
      btn = 1'b0;
      night = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      c = 0;
   endtask

   initial begin
      // idle after reset
      do_reset();
      chk_all("idle0", 3'd0, 3'b110, 2'b01, 1'b0);
      go(100);
      chk_all("idle100", 3'd0, 3'b110, 2'b01, 1'b0);
      go(200);
      chk_all("idle200", 3'd0, 3'b110, 2'b01, 1'b0);

      // full pedestrian cycle
      do_reset();
      go(2);  btn = 1'b1;
      go(7);  chk("cyc.req_before", {7'd0, req_pending}, 8'd0);
      go(8);  chk("cyc.req_rise", {7'd0, req_pending}, 8'd1);
      go(12); btn = 1'b0;
      go(15); chk("cyc.green_hold", {5'd0, state}, 8'd0);
      go(16); chk_all("cyc.yellow", 3'd1, 3'b101, 2'b01, 1'b1);
      go(27); chk("cyc.yellow_end", {5'd0, state}, 8'd1);
      go(28); chk_all("cyc.clr1", 3'd2, 3'b011, 2'b01, 1'b1);
      go(31); chk("cyc.clr1_end", {5'd0, state}, 8'd2);
      go(32); chk_all("cyc.walk", 3'd3, 3'b011, 2'b10, 1'b0);
      go(55); chk("cyc.walk_end", {5'd0, state}, 8'd3);
      go(56); chk_all("cyc.blink_on1", 3'd4, 3'b011, 2'b10, 1'b0);
      go(60); chk("cyc.blink_off1", {6'd0, ped_lamp}, 8'd3);
      go(64); chk("cyc.blink_on2", {6'd0, ped_lamp}, 8'd2);
      go(68); chk("cyc.blink_off2", {6'd0, ped_lamp}, 8'd3);
      go(71); chk("cyc.blink_end", {5'd0, state}, 8'd4);
      go(72); chk_all("cyc.clr2", 3'd5, 3'b011, 2'b01, 1'b0);
      go(75); chk("cyc.clr2_end", {5'd0, state}, 8'd5);
      go(76); chk_all("cyc.green", 3'd0, 3'b110, 2'b01, 1'b0);

      // short glitch rejected
      do_reset();
      go(2);  btn = 1'b1;
      go(4);  btn = 1'b0;
      go(10); chk("glitch.req", {7'd0, req_pending}, 8'd0);
      go(20); chk_all("glitch.after_tick4", 3'd0, 3'b110, 2'b01, 1'b0);

      // press during WALK served after minimum green
      do_reset();
      go(2);  btn = 1'b1;
      go(12); btn = 1'b0;
      go(36); chk("walkpress.in_walk", {5'd0, state}, 8'd3);
      btn = 1'b1;
      go(46); btn = 1'b0;
      go(56); chk("walkpress.blink_state", {5'd0, state}, 8'd4);
      chk("walkpress.blink_req", {7'd0, req_pending}, 8'd1);
      go(73); chk("walkpress.clr2_state", {5'd0, state}, 8'd5);
      chk("walkpress.clr2_req", {7'd0, req_pending}, 8'd1);
      go(76); chk_all("walkpress.green", 3'd0, 3'b110, 2'b01, 1'b1);
      go(91); chk("walkpress.green_end", {5'd0, state}, 8'd0);
      go(92); chk("walkpress.yellow", {5'd0, state}, 8'd1);

      // night flashing mode
      do_reset();
      go(17); night = 1'b1;
      go(19); chk("night.green", {5'd0, state}, 8'd0);
      go(20); chk_all("night.flash_on1", 3'd6, 3'b101, 2'b11, 1'b0);
      go(22); btn = 1'b1;
      go(24); chk_all("night.flash_off1", 3'd6, 3'b111, 2'b11, 1'b0);
      go(28); chk("night.flash_on2", {5'd0, car_lamp}, 8'd5);
      go(30); chk("night.req", {7'd0, req_pending}, 8'd1);
      chk("night.still_flash", {5'd0, state}, 8'd6);
      go(32); btn = 1'b0;
      go(33); night = 1'b0;
      go(35); chk("night.flash_end", {5'd0, state}, 8'd6);
      go(36); chk_all("night.green", 3'd0, 3'b110, 2'b01, 1'b1);
      go(51); chk("night.green_end", {5'd0, state}, 8'd0);
      go(52); chk("night.yellow", {5'd0, state}, 8'd1);

      // asynchronous reset during WALK
      do_reset();
      go(2);  btn = 1'b1;
      go(12); btn = 1'b0;
      go(36); btn = 1'b1;
      go(44); chk("rst.walk", {5'd0, state}, 8'd3);
      chk("rst.req_set", {7'd0, req_pending}, 8'd1);
      #2;
      rst_n = 1'b0;
      btn = 1'b0;
      #1;
      chk_all("rst.async", 3'd0, 3'b110, 2'b01, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      c = 0;
      go(3);  chk_all("rst.release", 3'd0, 3'b110, 2'b01, 1'b0);
      go(20); chk_all("rst.later", 3'd0, 3'b110, 2'b01, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
